// File: rtl/riscv_mem_pkg.sv
// Shared types and width helpers for the cache refill/writeback arbiter.
// Imported by the round-robin grant logic and the arbiter top.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd1,
    StDone  = 2'd2
  } arb_state_t;

  typedef enum logic {
    ArbIc = 1'b0,
    ArbDc = 1'b1
  } arb_client_t;

  function automatic int unsigned line_width(input int unsigned beats,
                                             input int unsigned data_w);
    return beats * data_w;
  endfunction

  function automatic int unsigned beat_off_bits(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned line_off_bits(input int unsigned beats,
                                                input int unsigned data_w);
    return $clog2((beats * data_w) / 8);
  endfunction

endpackage

// File: rtl/riscv_mem_rr_arbiter.sv
// Two-input round-robin grant: a lone requester wins outright, a tie goes to the
// client that was not granted last. The last-grant state lives in the caller.
module riscv_mem_rr_arbiter
  import riscv_mem_pkg::*;
(
  input  logic ic_req_i,
  input  logic dc_req_i,
  input  logic last_dc_i,
  output logic gnt_valid_o,
  output logic gnt_dc_o
);

  always_comb begin
    gnt_valid_o = ic_req_i | dc_req_i;
    if (ic_req_i && dc_req_i) begin
      gnt_dc_o = ~last_dc_i;
    end else begin
      gnt_dc_o = dc_req_i;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Refill/writeback arbiter between the instruction and data caches and a single
// beat-wide handshaked memory port; serialises one whole line per grant.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LINE_BEATS = 2
) (
  input  logic                         i_riscv_arb_clk,
  input  logic                         i_riscv_arb_rst,

  input  logic                         i_riscv_arb_ic_req,
  input  logic [ADDR_W-1:0]            i_riscv_arb_ic_addr,
  output logic                         o_riscv_arb_ic_done,

  input  logic                         i_riscv_arb_dc_req,
  input  logic                         i_riscv_arb_dc_we,
  input  logic [ADDR_W-1:0]            i_riscv_arb_dc_addr,
  input  logic [LINE_BEATS*DATA_W-1:0] i_riscv_arb_dc_wdata,
  output logic                         o_riscv_arb_dc_done,

  output logic [LINE_BEATS*DATA_W-1:0] o_riscv_arb_rdata,

  output logic                         o_riscv_arb_mem_req,
  output logic                         o_riscv_arb_mem_we,
  output logic [ADDR_W-1:0]            o_riscv_arb_mem_addr,
  output logic [DATA_W-1:0]            o_riscv_arb_mem_wdata,
  input  logic                         i_riscv_arb_mem_ack,
  input  logic [DATA_W-1:0]            i_riscv_arb_mem_rdata
);

  localparam int unsigned LineW   = line_width(LINE_BEATS, DATA_W);
  localparam int unsigned BeatOff = beat_off_bits(DATA_W);
  localparam int unsigned LineOff = line_off_bits(LINE_BEATS, DATA_W);
  localparam int unsigned BeatW   = $clog2(LINE_BEATS);
  localparam int unsigned TagW    = ADDR_W - LineOff;

  localparam logic [BeatW-1:0] LastBeat = BeatW'(LINE_BEATS - 1);

  arb_state_t                          state_q, state_d;
  arb_client_t                         client_q, client_d;
  arb_client_t                         last_q, last_d;
  logic                                we_q, we_d;
  logic [BeatW-1:0]                    beat_q, beat_d;
  logic [TagW-1:0]                     line_q, line_d;
  logic [LINE_BEATS-1:0][DATA_W-1:0]   wbuf_q, wbuf_d;
  logic [LINE_BEATS-1:0][DATA_W-1:0]   rdata_q, rdata_d;

  logic        gnt_valid;
  logic        gnt_dc;
  logic [ADDR_W-1:0] gnt_addr;

  // Offset bits within a line are discarded: bursts always start at beat 0.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_riscv_arb_ic_addr[LineOff-1:0],
                              i_riscv_arb_dc_addr[LineOff-1:0]};

  riscv_mem_rr_arbiter u_rr_arbiter (
    .ic_req_i    (i_riscv_arb_ic_req),
    .dc_req_i    (i_riscv_arb_dc_req),
    .last_dc_i   (last_q == ArbDc),
    .gnt_valid_o (gnt_valid),
    .gnt_dc_o    (gnt_dc)
  );

  assign gnt_addr = gnt_dc ? i_riscv_arb_dc_addr : i_riscv_arb_ic_addr;

  always_ff @(posedge i_riscv_arb_clk) begin
    if (i_riscv_arb_rst) begin
      state_q  <= StIdle;
      client_q <= ArbIc;
      last_q   <= ArbIc;
      we_q     <= 1'b0;
      beat_q   <= '0;
      line_q   <= '0;
      wbuf_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      client_q <= client_d;
      last_q   <= last_d;
      we_q     <= we_d;
      beat_q   <= beat_d;
      line_q   <= line_d;
      wbuf_q   <= wbuf_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    client_d = client_q;
    last_d   = last_q;
    we_d     = we_q;
    beat_d   = beat_q;
    line_d   = line_q;
    wbuf_d   = wbuf_q;
    rdata_d  = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          state_d  = StBurst;
          client_d = gnt_dc ? ArbDc : ArbIc;
          we_d     = gnt_dc & i_riscv_arb_dc_we;
          beat_d   = '0;
          line_d   = gnt_addr[ADDR_W-1:LineOff];
          wbuf_d   = gnt_dc ? i_riscv_arb_dc_wdata : '0;
        end
      end
      StBurst: begin
        if (i_riscv_arb_mem_ack) begin
          if (!we_q) begin
            rdata_d[beat_q] = i_riscv_arb_mem_rdata;
          end
          beat_d = beat_q + 1'b1;
          if (beat_q == LastBeat) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        last_d  = client_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_riscv_arb_mem_req   = 1'b0;
    o_riscv_arb_mem_we    = 1'b0;
    o_riscv_arb_mem_addr  = '0;
    o_riscv_arb_mem_wdata = '0;
    o_riscv_arb_ic_done   = 1'b0;
    o_riscv_arb_dc_done   = 1'b0;

    unique case (state_q)
      StBurst: begin
        o_riscv_arb_mem_req   = 1'b1;
        o_riscv_arb_mem_we    = we_q;
        // Beat index drops straight into the offset field, so no carry into the tag.
        o_riscv_arb_mem_addr  = {line_q, beat_q, {BeatOff{1'b0}}};
        o_riscv_arb_mem_wdata = wbuf_q[beat_q];
      end
      StDone: begin
        o_riscv_arb_ic_done = (client_q == ArbIc);
        o_riscv_arb_dc_done = (client_q == ArbDc);
      end
      default: ;
    endcase
  end

  assign o_riscv_arb_rdata = LineW'(rdata_q);

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Refill/writeback arbiter sitting directly downstream of `riscv_instructions_cache` and `riscv_data_cache`. Accepts whole-line requests from both caches (icache refill reads, dcache refill reads and dirty-line writebacks). Grants one client at a time with two-way round-robin. Serialises the granted line into `LINE_BEATS` beats on a single handshaked main-memory port, then returns the assembled line with a one-cycle done pulse.

## Interface
- `ADDR_W`, 64, physical address width.
- `DATA_W`, 64, memory beat width in bits.
- `LINE_BEATS`, 2, beats per cache line (power of two, ≥2); line width `LINE_W = LINE_BEATS*DATA_W`.
- `i_riscv_arb_clk` in 1: single clock, rising edge.
- `i_riscv_arb_rst` in 1: reset, synchronous and active-high.
- `i_riscv_arb_ic_req` in 1: icache line-read request (level).
- `i_riscv_arb_ic_addr` in ADDR_W: icache miss address.
- `o_riscv_arb_ic_done` out 1: one-cycle pulse, icache line valid on `o_riscv_arb_rdata`.
- `i_riscv_arb_dc_req` in 1: dcache request (level).
- `i_riscv_arb_dc_we` in 1: 1 = writeback, 0 = refill read.
- `i_riscv_arb_dc_addr` in ADDR_W: dcache line address.
- `i_riscv_arb_dc_wdata` in LINE_W: writeback line.
- `o_riscv_arb_dc_done` out 1: one-cycle pulse, dcache transaction complete.
- `o_riscv_arb_rdata` out LINE_W: assembled read line (shared by both clients).
- `o_riscv_arb_mem_req` out 1: beat request to memory.
- `o_riscv_arb_mem_we` out 1: beat is a write.
- `o_riscv_arb_mem_addr` out ADDR_W: beat byte address.
- `o_riscv_arb_mem_wdata` out DATA_W: write beat.
- `i_riscv_arb_mem_ack` in 1: current beat accepted/returned this cycle.
- `i_riscv_arb_mem_rdata` in DATA_W: read beat, valid when ack high.

## Operation
- FSM states: IDLE, BURST, DONE.
- IDLE: samples both reqs.
  - With one request asserted, that client is granted.
  - With both asserted, the client not granted last wins. The last-grant register resets to icache, so dcache wins the first tie.
  - On grant, latch client ID, `we` (0 for icache), line base = addr with low `log2(LINE_W/8)` bits cleared, and the dcache wdata line. Clear beat counter. Go to BURST.
- BURST:
  - `mem_req`=1.
  - `mem_addr` = base + beat*(DATA_W/8).
  - `mem_wdata` = latched line slice `[beat*DATA_W +: DATA_W]`; beat 0 is the least significant slice.
  - On ack, read data is written into the same slice of the line buffer and the beat counter increments.
  - Ack on the last beat moves to DONE.
- DONE: pulse the granted client's done for one cycle, update last-grant, return to IDLE. No request is sampled in DONE.
- `o_riscv_arb_rdata` holds its value until overwritten by a later read beat. Writebacks leave it unchanged.
- Clients hold req and address stable until done and drop req the cycle after done. A req still high in the IDLE cycle following DONE is treated as a new request.
- `i_riscv_arb_mem_ack` is ignored outside BURST.

## Timing
- Reset values: FSM = IDLE, beat counter = 0, last-grant = icache, `o_riscv_arb_rdata` = 0, all done/mem_req/mem_we = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Latency with zero-wait memory (ack in every BURST cycle): req sampled at edge 0, BURST cycles 1..LINE_BEATS, done high in cycle LINE_BEATS+1.
- Each wait cycle (req=1, ack=0) adds one cycle. `mem_addr`, `mem_we` and `mem_wdata` are held stable while unacked.
- `mem_req` stays continuously high across the beats of one line. It drops in DONE.
- Requests asserted while busy wait in IDLE; no queueing beyond the level req.
- Reset mid-burst: next cycle is IDLE with `mem_req`=0 and no done pulse. A memory ack arriving afterwards is ignored.
- Address arithmetic: beat offsets add into the low bits only and never carry past the line boundary.

## Structure
- Package `riscv_mem_pkg`:
  - state enum `arb_state_t` {IDLE, BURST, DONE};
  - client enum `arb_client_t` {ARB_IC, ARB_DC};
  - line/beat width localparam functions.
- Sub-module `riscv_mem_rr_arbiter`: combinational two-input round-robin grant from the two reqs plus the last-grant register; the register itself stays in the top FSM.

## Test plan
- Icache alone, addr 0x1008, zero-wait memory: beats at 0x1000, 0x1008 with we=0; `ic_done` in cycle 3; rdata = {beat1, beat0}; `dc_done` stays 0.
- Dcache writeback, addr 0x2010, wdata = {0xBBBB, 0xAAAA}: beats 0x2010/0xAAAA then 0x2018/0xBBBB with we=1; `dc_done` pulses; rdata unchanged.
- Both reqs in the same cycle after reset: dcache served first, icache granted in the IDLE after DONE; the next tie grants icache.
- Memory holds ack low 3 cycles on beat 0: address/wdata stable throughout, done delayed by exactly 3 cycles.
- Reset asserted in BURST after beat 0 ack: `mem_req`=0 next cycle, no done, rdata = 0; a subsequent request completes normally.
- Client holds req one extra cycle after done: a second full burst is issued, confirming the documented level semantics.
